// File: rtl/sram_bridge_wide.sv
// sram_bridge_wide: bridges a host word bus to a narrow asynchronous SRAM.
// Each host word is split into BEATS = HOST_DW/MEM_DW beats. Each beat runs
// SETUP -> ACCESS (WAIT_CYCLES) -> HOLD. Write beats whose byte lanes are all
// deselected are skipped. Every pin is registered, and every pin is forced to its
// idle level by the asynchronous reset.
module sram_bridge_wide #(
  parameter int HOST_DW     = 32,
  parameter int MEM_DW      = 8,
  parameter int MEM_AW      = 17,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_stb,
  input  logic                 s_we,
  input  logic [MEM_AW-1:0]    s_addr,
  input  logic [HOST_DW-1:0]   s_wdata,
  input  logic [HOST_DW/8-1:0] s_sel,
  output logic [HOST_DW-1:0]   s_rdata,
  output logic                 s_ack,
  output logic                 busy,
  output logic [MEM_AW-1:0]    sram_addr,
  output logic                 sram_cen,
  output logic                 sram_wen,
  output logic                 sram_oen,
  output logic [MEM_DW/8-1:0]  sram_ben,
  output logic [MEM_DW-1:0]    sram_dq_o,
  output logic                 sram_dq_oe,
  input  logic [MEM_DW-1:0]    sram_dq_i
);
  localparam int BEATS = HOST_DW / MEM_DW;
  localparam int LB    = $clog2(BEATS);
  localparam int BW    = (LB > 0) ? LB : 1;
  localparam int LANES = MEM_DW / 8;
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]     LAST_WAIT = CW'(WAIT_CYCLES - 1);
  localparam logic [MEM_AW-1:0] BEAT_MASK = MEM_AW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, ACK} state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [CW-1:0]        wcnt_q, wcnt_d;
  logic                 we_q, we_d;
  logic [MEM_AW-1:0]    addr_q, addr_d;
  logic [HOST_DW-1:0]   wdata_q, wdata_d;
  logic [HOST_DW/8-1:0] sel_q, sel_d;
  logic [BEATS-1:0]     en_q, en_d;
  logic [HOST_DW-1:0]   s_rdata_q, s_rdata_d;
  logic                 s_ack_q, s_ack_d;
  logic                 busy_q, busy_d;
  logic [MEM_AW-1:0]    sram_addr_q, sram_addr_d;
  logic                 sram_cen_q, sram_cen_d;
  logic                 sram_wen_q, sram_wen_d;
  logic                 sram_oen_q, sram_oen_d;
  logic [LANES-1:0]     sram_ben_q, sram_ben_d;
  logic [MEM_DW-1:0]    sram_dq_o_q, sram_dq_o_d;
  logic                 sram_dq_oe_q, sram_dq_oe_d;

  // Per-beat views of the request: write-lane presence, data and select slices.
  logic [BEATS-1:0]  en_wr, en_in;
  logic [MEM_DW-1:0] wslice [BEATS];
  logic [LANES-1:0]  sslice [BEATS];

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign en_wr[gi]  = |s_sel[gi*LANES +: LANES];
    assign wslice[gi] = wdata_d[gi*MEM_DW +: MEM_DW];
    assign sslice[gi] = sel_d[gi*LANES +: LANES];
  end

  // Reads touch every beat; writes only beats with at least one lane enabled.
  assign en_in = s_we ? en_wr : {BEATS{1'b1}};

  logic          first_found, next_found, active;
  logic [BW-1:0] first_idx, next_idx;

  // Next-state logic plus decode of the pin levels for the state being entered.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    wcnt_d       = wcnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    en_d         = en_q;
    s_rdata_d    = s_rdata_q;
    sram_addr_d  = sram_addr_q;
    sram_ben_d   = sram_ben_q;
    sram_dq_o_d  = sram_dq_o_q;

    first_found = |en_in;
    first_idx   = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (en_in[b]) first_idx = BW'(b);
    end

    next_found = 1'b0;
    next_idx   = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (en_q[b] && (BW'(b) > beat_q)) begin
        next_found = 1'b1;
        next_idx   = BW'(b);
      end
    end

    case (state_q)
      IDLE: begin
        if (s_stb) begin
          we_d    = s_we;
          addr_d  = s_addr;
          wdata_d = s_wdata;
          sel_d   = s_sel;
          en_d    = en_in;
          beat_d  = first_idx;
          state_d = (s_we && !first_found) ? ACK : SETUP;
        end
      end
      SETUP: begin
        wcnt_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (wcnt_q == LAST_WAIT) begin
          state_d = HOLD;
          if (!we_q) begin
            for (int b = 0; b < BEATS; b++) begin
              if (beat_q == BW'(b)) s_rdata_d[b*MEM_DW +: MEM_DW] = sram_dq_i;
            end
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (next_found) begin
          beat_d  = next_idx;
          state_d = SETUP;
        end else begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    active       = (state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD);
    sram_cen_d   = ~active;
    sram_wen_d   = ~((state_d == ACCESS) && we_d);
    sram_oen_d   = ~(((state_d == SETUP) || (state_d == ACCESS)) && !we_d);
    sram_dq_oe_d = active && we_d;
    s_ack_d      = (state_d == ACK);
    busy_d       = (state_d != IDLE);

    if (state_d == SETUP) begin
      // Beat index replaces the low address bits, so it never carries upward.
      sram_addr_d = (addr_d & ~BEAT_MASK) | MEM_AW'(beat_d);
      sram_ben_d  = we_d ? ~sslice[beat_d] : '0;
      if (we_d) sram_dq_o_d = wslice[beat_d];
    end else if (!active) begin
      sram_ben_d = '1;
    end
  end

  // State and registered pins; reset drops everything to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      wcnt_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      en_q         <= '0;
      s_rdata_q    <= '0;
      s_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
      sram_addr_q  <= '0;
      sram_cen_q   <= 1'b1;
      sram_wen_q   <= 1'b1;
      sram_oen_q   <= 1'b1;
      sram_ben_q   <= '1;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      wcnt_q       <= wcnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      s_rdata_q    <= s_rdata_d;
      s_ack_q      <= s_ack_d;
      busy_q       <= busy_d;
      sram_addr_q  <= sram_addr_d;
      sram_cen_q   <= sram_cen_d;
      sram_wen_q   <= sram_wen_d;
      sram_oen_q   <= sram_oen_d;
      sram_ben_q   <= sram_ben_d;
      sram_dq_o_q  <= sram_dq_o_d;
      sram_dq_oe_q <= sram_dq_oe_d;
    end
  end

  assign s_rdata    = s_rdata_q;
  assign s_ack      = s_ack_q;
  assign busy       = busy_q;
  assign sram_addr  = sram_addr_q;
  assign sram_cen   = sram_cen_q;
  assign sram_wen   = sram_wen_q;
  assign sram_oen   = sram_oen_q;
  assign sram_ben   = sram_ben_q;
  assign sram_dq_o  = sram_dq_o_q;
  assign sram_dq_oe = sram_dq_oe_q;

endmodule

// File: tb/tb_sram_bridge_wide.sv
// Bench for sram_bridge_wide: default instance (32/8, one wait state) plus a
// 64/16 instance with three wait states, each behind a behavioural SRAM.
module tb_sram_bridge_wide;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: default parameters ----------------
  logic        a_rst, a_stb, a_we;
  logic [16:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_sel;
  logic [31:0] a_rdata;
  logic        a_ack, a_busy;
  logic [16:0] a_saddr;
  logic        a_cen, a_wen, a_oen;
  logic [0:0]  a_ben;
  logic [7:0]  a_dqo, a_dqi;
  logic        a_dqoe;

  sram_bridge_wide u_a (
    .clk(clk), .rst(a_rst), .s_stb(a_stb), .s_we(a_we), .s_addr(a_addr),
    .s_wdata(a_wdata), .s_sel(a_sel), .s_rdata(a_rdata), .s_ack(a_ack),
    .busy(a_busy), .sram_addr(a_saddr), .sram_cen(a_cen), .sram_wen(a_wen),
    .sram_oen(a_oen), .sram_ben(a_ben), .sram_dq_o(a_dqo), .sram_dq_oe(a_dqoe),
    .sram_dq_i(a_dqi)
  );

  logic [7:0]  mem0   [0:1023] = '{default: 8'h00};
  logic [7:0]  shadow [0:1023] = '{default: 8'h00};
  logic [25:0] wq [$];
  logic [31:0] rq [$];
  logic        cur_we = 1'b0;
  logic [31:0] last_rd = 32'h0;

  assign a_dqi = (!a_cen && !a_oen) ? mem0[a_saddr[9:0]] : 8'h00;

  // SRAM model write port; every write cycle is matched against the scoreboard.
  always @(negedge clk) begin
    if (!a_cen && !a_wen) begin
      if (!a_ben[0]) mem0[a_saddr[9:0]] <= a_dqo;
      check("sram_write", 64'({a_ben, a_saddr, a_dqo}),
            64'((wq.size() > 0) ? wq.pop_front() : 26'h3FFFFFF));
    end
  end

  task automatic drive_a(input logic we, input logic [16:0] addr,
                         input logic [31:0] wd, input logic [3:0] sel);
    logic [16:0] base;
    logic [31:0] word;
    for (int k = 0; k < 100 && a_busy; k++) @(negedge clk);
    base    = addr & ~17'h3;
    a_stb   = 1'b1;
    a_we    = we;
    a_addr  = addr;
    a_wdata = wd;
    a_sel   = sel;
    cur_we  = we;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) begin
          wq.push_back({1'b0, base | 17'(b), wd[b*8 +: 8]});
          shadow[base[9:0] | 10'(b)] = wd[b*8 +: 8];
        end
      end
    end else begin
      word = 32'h0;
      for (int b = 0; b < 4; b++) word[b*8 +: 8] = shadow[base[9:0] | 10'(b)];
      rq.push_back(word);
    end
  endtask

  task automatic wait_a(input bit keep, output int lat, output int wen_lo,
                        output int oen_lo, output int cen_lo, output int oe_hi,
                        output logic oe_at_ack);
    logic [31:0] exp_w;
    lat = -1; wen_lo = 0; oen_lo = 0; cen_lo = 0; oe_hi = 0; oe_at_ack = 1'bx;
    @(posedge clk);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1 && !keep) a_stb = 1'b0;
      if (!a_wen) wen_lo++;
      if (!a_oen) oen_lo++;
      if (!a_cen) cen_lo++;
      if (a_dqoe) oe_hi++;
      if (a_ack) begin
        lat = i;
        oe_at_ack = a_dqoe;
        break;
      end
    end
    if (cur_we) begin
      check("rdata_kept_on_write", 64'(a_rdata), 64'(last_rd));
    end else begin
      exp_w = rq.pop_front();
      check("read_word", 64'(a_rdata), 64'(exp_w));
      last_rd = exp_w;
    end
    $display("txn we=%0b addr=%05h lat=%0d rdata=%08h", cur_we, a_addr, lat, a_rdata);
  endtask

  // ---------------- instance B: 64/16 with three wait states ----------------
  logic        b_rst, b_stb, b_we;
  logic [16:0] b_addr;
  logic [63:0] b_wdata;
  logic [7:0]  b_sel;
  logic [63:0] b_rdata;
  logic        b_ack, b_busy;
  logic [16:0] b_saddr;
  logic        b_cen, b_wen, b_oen;
  logic [1:0]  b_ben;
  logic [15:0] b_dqo, b_dqi;
  logic        b_dqoe;

  sram_bridge_wide #(.HOST_DW(64), .MEM_DW(16), .MEM_AW(17), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst(b_rst), .s_stb(b_stb), .s_we(b_we), .s_addr(b_addr),
    .s_wdata(b_wdata), .s_sel(b_sel), .s_rdata(b_rdata), .s_ack(b_ack),
    .busy(b_busy), .sram_addr(b_saddr), .sram_cen(b_cen), .sram_wen(b_wen),
    .sram_oen(b_oen), .sram_ben(b_ben), .sram_dq_o(b_dqo), .sram_dq_oe(b_dqoe),
    .sram_dq_i(b_dqi)
  );

  logic [15:0] mem1 [0:255] = '{default: 16'h0000};
  assign b_dqi = (!b_cen && !b_oen) ? mem1[b_saddr[7:0]] : 16'h0000;

  always @(negedge clk) begin
    if (!b_cen && !b_wen) begin
      if (!b_ben[0]) mem1[b_saddr[7:0]][7:0]  <= b_dqo[7:0];
      if (!b_ben[1]) mem1[b_saddr[7:0]][15:8] <= b_dqo[15:8];
    end
  end

  int   lat, wlo, olo, clo, ohi;
  logic oea;
  logic ack_seen;
  logic [16:0] bw_addr;
  logic [15:0] bw_data;
  logic [1:0]  bw_ben;

  initial begin
    a_rst = 1'b1; a_stb = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_sel = '0;
    b_rst = 1'b1; b_stb = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_sel = '0;
    #1;
    check("rst_rdata", 64'(a_rdata), 64'h0);
    check("rst_ack_busy", 64'({a_ack, a_busy}), 64'h0);
    check("rst_ctrl_pins", 64'({a_cen, a_wen, a_oen, a_ben, a_dqoe}), 64'b11110);
    check("rst_addr_dq", 64'({a_saddr, a_dqo}), 64'h0);
    @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);

    // Full write: four beats, one wait state each.
    drive_a(1'b1, 17'h00104, 32'hA1B2C3D4, 4'hF);
    wait_a(1'b0, lat, wlo, olo, clo, ohi, oea);
    check("full_wr_latency", 64'(lat), 64'(13));
    check("full_wr_wen_cycles", 64'(wlo), 64'(4));
    check("full_wr_cen_cycles", 64'(clo), 64'(12));
    check("full_wr_oe_in_ack", 64'(oea), 64'h0);

    // Full read back of the same word.
    drive_a(1'b0, 17'h00104, 32'h0, 4'h0);
    wait_a(1'b0, lat, wlo, olo, clo, ohi, oea);
    check("full_rd_latency", 64'(lat), 64'(13));
    check("full_rd_oen_cycles", 64'(olo), 64'(8));
    check("full_rd_dq_oe", 64'(ohi), 64'(0));

    // Unaligned read address resolves to the same aligned word.
    drive_a(1'b0, 17'h00107, 32'h0, 4'h0);
    wait_a(1'b0, lat, wlo, olo, clo, ohi, oea);
    check("unaligned_rd_latency", 64'(lat), 64'(13));

    // Sparse write: only lanes 1 and 3.
    drive_a(1'b1, 17'h00108, 32'h11223344, 4'b1010);
    wait_a(1'b0, lat, wlo, olo, clo, ohi, oea);
    check("sparse_wr_latency", 64'(lat), 64'(7));
    check("sparse_wr_wen_cycles", 64'(wlo), 64'(2));
    drive_a(1'b0, 17'h00108, 32'h0, 4'h0);
    wait_a(1'b0, lat, wlo, olo, clo, ohi, oea);

    // Empty select: no SRAM cycle at all.
    drive_a(1'b1, 17'h0010C, 32'hDEADBEEF, 4'h0);
    wait_a(1'b0, lat, wlo, olo, clo, ohi, oea);
    check("nosel_wr_latency", 64'(lat), 64'(1));
    check("nosel_wr_cen_cycles", 64'(clo), 64'(0));

    // Unaligned write lands on the aligned word without carry.
    drive_a(1'b1, 17'h0010E, 32'h0F0E0D0C, 4'hF);
    wait_a(1'b0, lat, wlo, olo, clo, ohi, oea);
    check("unaligned_wr_latency", 64'(lat), 64'(13));
    drive_a(1'b0, 17'h0010C, 32'h0, 4'h0);
    wait_a(1'b0, lat, wlo, olo, clo, ohi, oea);

    // Reset asserted during the ACCESS phase of beat 2.
    drive_a(1'b1, 17'h00200, 32'h55667788, 4'hF);
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) a_stb = 1'b0;
    end
    check("mid_wen_before_rst", 64'(a_wen), 64'h0);
    #1 a_rst = 1'b1;
    #1;
    check("mid_rst_pins", 64'({a_cen, a_wen, a_oen, a_dqoe, a_busy}), 64'b11100);
    check("mid_rst_rdata", 64'(a_rdata), 64'h0);
    ack_seen = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack_seen = ack_seen | a_ack;
    end
    check("mid_rst_no_ack", 64'(ack_seen), 64'h0);
    check("mid_rst_beats_left", 64'(wq.size()), 64'(1));
    wq.delete();
    shadow[10'h203] = 8'h00;
    last_rd = 32'h0;
    drive_a(1'b0, 17'h00200, 32'h0, 4'h0);
    wait_a(1'b0, lat, wlo, olo, clo, ohi, oea);
    check("post_rst_rd_latency", 64'(lat), 64'(13));

    // Back-to-back write then read with the strobe held high throughout.
    drive_a(1'b1, 17'h00300, 32'hCAFEF00D, 4'hF);
    wait_a(1'b1, lat, wlo, olo, clo, ohi, oea);
    check("b2b_wr_latency", 64'(lat), 64'(13));
    check("b2b_wr_oe_in_ack", 64'(oea), 64'h0);
    drive_a(1'b0, 17'h00300, 32'h0, 4'h0);
    check("b2b_idle_gap", 64'({a_busy, a_dqoe, a_oen}), 64'b001);
    wait_a(1'b0, lat, wlo, olo, clo, ohi, oea);
    check("b2b_rd_latency", 64'(lat), 64'(13));
    check("b2b_rd_dq_oe", 64'(ohi), 64'(0));
    check("wq_drained", 64'(wq.size()), 64'(0));

    // Wide instance: single beat 2 write with three wait states.
    b_stb = 1'b1; b_we = 1'b1; b_addr = 17'h00040;
    b_wdata = 64'h0123456789ABCDEF; b_sel = 8'h30;
    @(posedge clk);
    lat = -1; wlo = 0; clo = 0; bw_addr = '0; bw_data = '0; bw_ben = 2'b11;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) b_stb = 1'b0;
      if (!b_cen) clo++;
      if (!b_wen) begin
        wlo++;
        bw_addr = b_saddr; bw_data = b_dqo; bw_ben = b_ben;
      end
      if (b_ack) begin lat = i; break; end
    end
    $display("txn wide we=1 addr=%05h lat=%0d", b_addr, lat);
    check("wide_wr_latency", 64'(lat), 64'(6));
    check("wide_wr_wen_cycles", 64'(wlo), 64'(3));
    check("wide_wr_cen_cycles", 64'(clo), 64'(5));
    check("wide_wr_beat", 64'({bw_ben, bw_addr, bw_data}), 64'({2'b00, 17'h00042, 16'h4567}));
    check("wide_wr_rdata_kept", b_rdata, 64'h0);

    // Wide read back from an unaligned address.
    @(negedge clk);
    b_stb = 1'b1; b_we = 1'b0; b_addr = 17'h00043;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) b_stb = 1'b0;
      if (b_ack) begin lat = i; break; end
    end
    $display("txn wide we=0 addr=%05h lat=%0d rdata=%016h", b_addr, lat, b_rdata);
    check("wide_rd_latency", 64'(lat), 64'(21));
    check("wide_rd_word", b_rdata, 64'h0000456700000000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_bridge_wide.md
Name: sram_bridge_wide

Overview:
- Parametrised successor to the team's single-byte SRAM controller.
- Bridges a host word bus to an asynchronous narrow SRAM, splitting each host word into HOST_DW/MEM_DW sequential beats.
- Adds a byte-lane select, skipped write beats, programmable access wait states, a split tri-state data bus and a single-cycle ack handshake.
- Sits between the Wishbone slave front end and the board SRAM pins.

Parameters:
- HOST_DW, 32, host data width; must be a multiple of MEM_DW.
- MEM_DW, 8, SRAM data width; must be a multiple of 8.
- MEM_AW, 17, SRAM address width.
- WAIT_CYCLES, 1, ACCESS-phase cycles per beat; minimum 1.
- BEATS, HOST_DW/MEM_DW, derived; LB = log2(BEATS).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_stb  in  1  request strobe.
- s_we  in  1  1 = write, 0 = read.
- s_addr  in  MEM_AW  SRAM-unit address; low LB bits ignored, so the word is aligned.
- s_wdata  in  HOST_DW  write data.
- s_sel  in  HOST_DW/8  byte-lane enables for writes.
- s_rdata  out  HOST_DW  read data.
- s_ack  out  1  completion pulse.
- busy  out  1  high while not IDLE.
- sram_addr  out  MEM_AW  SRAM address.
- sram_cen  out  1  chip enable, active low.
- sram_wen  out  1  write enable, active low.
- sram_oen  out  1  output enable, active low.
- sram_ben  out  MEM_DW/8  byte enables, active low.
- sram_dq_o  out  MEM_DW  write data to pad.
- sram_dq_oe  out  1  pad drive enable.
- sram_dq_i  in  MEM_DW  read data from pad.

Behaviour:
- Reset values (async; all outputs take them immediately, including mid-transaction):
  - s_rdata=0, s_ack=0, busy=0, sram_addr=0.
  - sram_cen=sram_wen=sram_oen=1, sram_ben all 1.
  - sram_dq_o=0, sram_dq_oe=0.
  - FSM goes to IDLE.
- States: IDLE, SETUP, ACCESS, HOLD, ACK.
- IDLE:
  - On s_stb=1, latch we/addr/wdata/sel and select the first beat.
  - Write: the first beat is the lowest beat with any sel bit set in its lanes. If none is set, go directly to ACK (no SRAM cycle).
  - Read: all beats are executed, starting at beat 0.
- SETUP (1 cycle):
  - sram_addr = {addr[MEM_AW-1:LB], beat}; sram_cen=0.
  - Write: sram_dq_oe=1, dq_o = beat slice, ben = ~sel slice, wen=1.
  - Read: oen=0, ben all 0.
- ACCESS (WAIT_CYCLES cycles):
  - Write: wen=0.
  - Read: oen=0. sram_dq_i is captured into s_rdata slice [beat*MEM_DW +: MEM_DW] at the clock edge ending the last ACCESS cycle.
- HOLD (1 cycle):
  - wen=1 and oen=1; cen stays 0; addr, dq_o and dq_oe are held, giving write data hold time.
  - Then go to the next enabled beat's SETUP. If no beat remains, go to ACK.
  - Write beats with all-zero sel are skipped entirely.
- ACK (1 cycle):
  - s_ack=1; cen/wen/oen=1; dq_oe=0; then IDLE.
  - The ACK cycle guarantees at least one cycle of bus turnaround between any write drive and a following read.
- Timing:
  - Latency from the accept edge to s_ack high = N*(WAIT_CYCLES+2)+1 cycles, N = beats executed.
  - A request held on s_stb after ack is accepted as a new transaction in the following IDLE cycle; back-to-back throughput is one IDLE cycle between transactions.
- s_stb dropped mid-transaction: ignored; the transaction completes and s_ack still pulses.
- Inputs other than s_stb are don't-care while busy=1.
- s_rdata is updated only by read beats. Unread slices and the value after ack hold until the next read overwrites them. Write transactions never change s_rdata.
- Address: beat index wraps within the aligned word; there is no carry into the upper address bits.
- Reset asserted mid-beat:
  - Pins return to idle the same instant.
  - The partial word is discarded; no ack is issued.
  - The first request after reset release starts cleanly from IDLE.

Test Plan:
- Full write (default params, WAIT=1): addr=0x00104, wdata=0xA1B2C3D4, sel=4'hF -> four SRAM writes to 0x104..0x107 with data D4, C3, B2, A1; wen low exactly 1 cycle per beat; s_ack 13 cycles after accept; dq_oe=0 in ACK.
- Full read after the above, from a behavioural SRAM model -> s_rdata=0xA1B2C3D4 with s_ack 13 cycles after accept; oen low only in SETUP/ACCESS; dq_oe=0 throughout.
- Sparse write, sel=4'b1010, wdata=0x11223344 -> only addresses +1 (0x33) and +3 (0x11) are written; ack after 7 cycles. sel=0 -> no cen pulse, ack 1 cycle after accept.
- WAIT_CYCLES=3, HOST_DW=64, MEM_DW=16, sel=8'h30 -> one beat (beat 2), ben=2'b00 for that beat; ACCESS lasts 3 cycles; ack after 6 cycles.
- Reset mid-transaction: assert rst during the beat-2 ACCESS of a write -> cen/wen/oen=1, dq_oe=0 and busy=0 asynchronously; no s_ack; a subsequent read completes normally.
- Back-to-back: write then read with s_stb held high continuously -> exactly one IDLE cycle between the write ack and the read SETUP; dq_oe low for at least 2 cycles before oen falls.
